// File: rtl/rc4_pkg.sv
// Shared RC4 types: byte type, PRGA state encoding, default message length
// and the printable-character test used by the early key-rejection check.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int MSG_LEN_DEFAULT = 32;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'd0,
    ST_INC_I = 5'd1,
    ST_RD_I  = 5'd2,
    ST_WT_I  = 5'd3,
    ST_CAP_I = 5'd4,
    ST_RD_J  = 5'd5,
    ST_WT_J  = 5'd6,
    ST_CAP_J = 5'd7,
    ST_WR_I  = 5'd8,
    ST_WR_J  = 5'd9,
    ST_RD_F  = 5'd10,
    ST_WT_F  = 5'd11,
    ST_CAP_F = 5'd12,
    ST_WR_D  = 5'd13,
    ST_CHECK = 5'd14,
    ST_DONE  = 5'd15,
    ST_FAIL  = 5'd16
  } state_e;

  // Lower-case letters and space are the only characters a correct key yields.
  function automatic logic is_valid_char(input byte_t c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h20);
  endfunction

endpackage

// File: rtl/prga_decrypt_if.sv
// Memory-side bundle of the PRGA decryptor: S RAM, encrypted ROM, decrypted RAM.
interface prga_decrypt_if;
  import rc4_pkg::*;

  byte_t s_address;
  logic  s_wren;
  byte_t s_data;
  byte_t s_q;
  byte_t e_address;
  byte_t e_q;
  byte_t d_address;
  logic  d_wren;
  byte_t d_data;

  modport master (
    output s_address, s_wren, s_data, e_address, d_address, d_wren, d_data,
    input  s_q, e_q
  );

  modport slave (
    input  s_address, s_wren, s_data, e_address, d_address, d_wren, d_data,
    output s_q, e_q
  );

endinterface

// File: rtl/prga_decrypt.sv
// RC4 PRGA loop: swaps S entries and writes D[k] = keystream ^ E[k], 14 cycles per byte.
// Define PRGA_ASCII_CHECK_EN to abort (fail) on the first non [a-z ] decrypted byte.
module prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  prga_decrypt_if.master mem,
  output logic           done,
  output logic           fail
);

  localparam logic [4:0] IDLE  = ST_IDLE;
  localparam logic [4:0] INC_I = ST_INC_I;
  localparam logic [4:0] RD_I  = ST_RD_I;
  localparam logic [4:0] WT_I  = ST_WT_I;
  localparam logic [4:0] CAP_I = ST_CAP_I;
  localparam logic [4:0] RD_J  = ST_RD_J;
  localparam logic [4:0] WT_J  = ST_WT_J;
  localparam logic [4:0] CAP_J = ST_CAP_J;
  localparam logic [4:0] WR_I  = ST_WR_I;
  localparam logic [4:0] WR_J  = ST_WR_J;
  localparam logic [4:0] RD_F  = ST_RD_F;
  localparam logic [4:0] WT_F  = ST_WT_F;
  localparam logic [4:0] CAP_F = ST_CAP_F;
  localparam logic [4:0] WR_D  = ST_WR_D;
  localparam logic [4:0] CHECK = ST_CHECK;
  localparam logic [4:0] DONE  = ST_DONE;
`ifdef PRGA_ASCII_CHECK_EN
  localparam logic [4:0] FAIL  = ST_FAIL;
`endif

  localparam byte_t K_LAST = byte_t'(MSG_LEN - 1);

  logic [4:0] state;
  byte_t      i, j, k, si, sj, f, e_byte;
  byte_t      dec;
  logic       char_ok;

  assign dec = f ^ e_byte;

`ifdef PRGA_ASCII_CHECK_EN
  logic fail_q;
  assign char_ok = is_valid_char(dec);
  assign fail    = fail_q;
`else
  assign char_ok = 1'b1;
  assign fail    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      si     <= '0;
      sj     <= '0;
      f      <= '0;
      e_byte <= '0;
      done   <= 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
      fail_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            state <= INC_I;
          end
        end
        INC_I: begin
          i     <= i + 8'd1;
          state <= RD_I;
        end
        RD_I:  state <= WT_I;
        WT_I:  state <= CAP_I;
        CAP_I: begin
          si    <= mem.s_q;
          j     <= j + mem.s_q;
          state <= RD_J;
        end
        RD_J:  state <= WT_J;
        WT_J:  state <= CAP_J;
        CAP_J: begin
          sj    <= mem.s_q;
          state <= WR_I;
        end
        WR_I:  state <= WR_J;
        WR_J:  state <= RD_F;
        RD_F:  state <= WT_F;
        WT_F:  state <= CAP_F;
        CAP_F: begin
          f      <= mem.s_q;
          e_byte <= mem.e_q;
          state  <= WR_D;
        end
        WR_D: begin
`ifdef PRGA_ASCII_CHECK_EN
          if (!char_ok) begin
            state  <= FAIL;
            fail_q <= 1'b1;
          end else begin
            state  <= CHECK;
          end
`else
          state <= CHECK;
`endif
        end
        CHECK: begin
          if (k == K_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            k     <= k + 8'd1;
            state <= INC_I;
          end
        end
        DONE: state <= DONE;
`ifdef PRGA_ASCII_CHECK_EN
        FAIL: state <= FAIL;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Addresses are held through the wait and capture cycles so the RAM output stays stable.
  always_comb begin
    mem.s_address = '0;
    mem.s_wren    = 1'b0;
    mem.s_data    = '0;
    mem.e_address = '0;
    mem.d_address = '0;
    mem.d_wren    = 1'b0;
    mem.d_data    = '0;
    case (state)
      RD_I, WT_I, CAP_I: mem.s_address = i;
      RD_J, WT_J, CAP_J: mem.s_address = j;
      WR_I: begin
        mem.s_address = i;
        mem.s_wren    = 1'b1;
        mem.s_data    = sj;
      end
      WR_J: begin
        mem.s_address = j;
        mem.s_wren    = 1'b1;
        mem.s_data    = si;
      end
      RD_F, WT_F, CAP_F: begin
        mem.s_address = si + sj;
        mem.e_address = k;
      end
      WR_D: begin
        mem.d_address = k;
        mem.d_data    = dec;
        mem.d_wren    = char_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga_decrypt.sv
// Scoreboarded bench for prga_decrypt: a reference RC4 model queues the expected
// S/D write sequence, which is compared against the DUT write strobes each cycle.
module tb_prga_decrypt;
  import rc4_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic done;
  logic fail;

  prga_decrypt_if bus ();

  prga_decrypt #(.MSG_LEN(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mem   (bus),
    .done  (done),
    .fail  (fail)
  );

  always #5 clk = ~clk;

  byte_t s_mem [256];
  byte_t e_mem [256];
  byte_t d_mem [256];

  // Registered-address RAM/ROM models.
  always @(posedge clk) begin
    if (bus.s_wren) s_mem[bus.s_address] <= bus.s_data;
    bus.s_q <= s_mem[bus.s_address];
    bus.e_q <= e_mem[bus.e_address];
    if (bus.d_wren) d_mem[bus.d_address] <= bus.d_data;
  end

  typedef struct packed {
    logic  is_d;
    byte_t addr;
    byte_t data;
  } wr_t;

  wr_t   exp_q[$];
  byte_t s_model [256];
  byte_t e_model [256];
  int    exp_end;
  bit    exp_fail;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic load(input byte_t e0, input byte_t e1, input byte_t e2, input bit wrap);
    for (int n = 0; n < 256; n++) begin
      s_model[n] = byte_t'(n);
      e_model[n] = 8'h00;
    end
    if (wrap) begin
      s_model[1]   = 8'hFF;
      s_model[255] = 8'h01;
    end
    e_model[0] = e0;
    e_model[1] = e1;
    e_model[2] = e2;
    for (int n = 0; n < 256; n++) begin
      s_mem[n] <= s_model[n];
      e_mem[n] <= e_model[n];
      d_mem[n] <= 8'hAA;
    end
  endtask

  task automatic build_expected();
    byte_t i, j, si, sj, fa, d;
    i = 8'h00;
    j = 8'h00;
    exp_q.delete();
    exp_fail = 1'b0;
    exp_end  = 14 * N;
    for (int k = 0; k < N; k++) begin
      i  = i + 8'd1;
      si = s_model[i];
      j  = j + si;
      sj = s_model[j];
      s_model[i] = sj;
      s_model[j] = si;
      fa = si + sj;
      d  = s_model[fa] ^ e_model[k];
      exp_q.push_back({1'b0, i, sj});
      exp_q.push_back({1'b0, j, si});
`ifdef PRGA_ASCII_CHECK_EN
      if (!(((d >= 8'h61) && (d <= 8'h7A)) || (d == 8'h20))) begin
        exp_fail = 1'b1;
        exp_end  = 14 * k + 13;
        break;
      end
`endif
      exp_q.push_back({1'b1, byte_t'(k), d});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Starts a run and scores every write strobe for a fixed 70-cycle window.
  task automatic run_scored(input string name, input int mid_pulse, input bit done_pulse);
    wr_t w, got;
    int  seen_end;
    build_expected();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen_end = -1;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ((bus.s_wren & bus.d_wren) !== 1'b0) begin
        n_fail++;
        $display("FAIL %s wren_overlap cycle %0d: s_wren=%b d_wren=%b, required not both", name, c, bus.s_wren, bus.d_wren);
      end
      if (bus.s_wren || bus.d_wren) begin
        got = {bus.d_wren, bus.d_wren ? bus.d_address : bus.s_address,
               bus.d_wren ? bus.d_data : bus.s_data};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected_write cycle %0d: got %h, required none", name, c, got);
        end else begin
          w = exp_q.pop_front();
          if (got !== w) begin
            n_fail++;
            $display("FAIL %s write cycle %0d: got %h, required %h", name, c, got, w);
          end
        end
      end
      if (seen_end < 0 && (done === 1'b1 || fail === 1'b1)) seen_end = c;
      start = (c == mid_pulse || (done_pulse && c == 55)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s missing_writes: %0d left, required 0", name, exp_q.size());
    end
    n_checks++;
    if (seen_end !== exp_end) begin
      n_fail++;
      $display("FAIL %s end_cycle: got %0d, required %0d", name, seen_end, exp_end);
    end
    n_checks++;
    if (done !== !exp_fail) begin
      n_fail++;
      $display("FAIL %s done: got %b, required %b", name, done, !exp_fail);
    end
    n_checks++;
    if (fail !== exp_fail) begin
      n_fail++;
      $display("FAIL %s fail: got %b, required %b", name, fail, exp_fail);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.s_address, bus.s_wren, bus.s_data, bus.e_address, bus.d_address,
         bus.d_wren, bus.d_data, done, fail} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {bus.s_address, bus.s_wren, bus.s_data, bus.e_address, bus.d_address,
                bus.d_wren, bus.d_data, done, fail});
    end
  endtask

  task automatic test_identity_zero();
    byte_t exp_s [3];
    byte_t exp_d [3];
    do_reset();
    load(8'h00, 8'h00, 8'h00, 1'b0);
    run_scored("identity_zero", 0, 1'b0);
`ifdef PRGA_ASCII_CHECK_EN
    exp_s = '{8'h02, 8'h03, 8'h05};
    exp_d = '{8'hAA, 8'hAA, 8'hAA};
`else
    exp_s = '{8'h03, 8'h05, 8'h02};
    exp_d = '{8'h02, 8'h05, 8'h07};
`endif
    n_checks++;
    if ({s_mem[2], s_mem[3], s_mem[5]} !== {exp_s[0], exp_s[1], exp_s[2]}) begin
      n_fail++;
      $display("FAIL identity_zero final_s: got %h %h %h, required %h %h %h",
               s_mem[2], s_mem[3], s_mem[5], exp_s[0], exp_s[1], exp_s[2]);
    end
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if (d_mem[n] !== exp_d[n]) begin
        n_fail++;
        $display("FAIL identity_zero d[%0d]: got %h, required %h", n, d_mem[n], exp_d[n]);
      end
    end
  endtask

  task automatic test_identity_text();
    byte_t exp_d [3];
    exp_d = '{8'h61, 8'h65, 8'h61};
    do_reset();
    load(8'h63, 8'h60, 8'h66, 1'b0);
    run_scored("identity_text", 20, 1'b1);
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if (d_mem[n] !== exp_d[n]) begin
        n_fail++;
        $display("FAIL identity_text d[%0d]: got %h, required %h", n, d_mem[n], exp_d[n]);
      end
    end
  endtask

  task automatic test_j_wrap();
    do_reset();
    load(8'h61, 8'h62, 8'h7D, 1'b1);
    run_scored("j_wrap", 0, 1'b0);
    n_checks++;
    if ({s_mem[1], s_mem[2], s_mem[255]} !== 24'h0201FF) begin
      n_fail++;
      $display("FAIL j_wrap final_s: got %h %h %h, required 02 01 ff", s_mem[1], s_mem[2], s_mem[255]);
    end
    n_checks++;
    if ({d_mem[0], d_mem[1], d_mem[2]} !== 24'h61617A) begin
      n_fail++;
      $display("FAIL j_wrap d: got %h %h %h, required 61 61 7a", d_mem[0], d_mem[1], d_mem[2]);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load(8'h63, 8'h60, 8'h66, 1'b0);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    // Byte 1 WR_J: j = 3, si = 2.
    n_checks++;
    if ({bus.s_wren, bus.s_address, bus.s_data} !== {1'b1, 8'h03, 8'h02}) begin
      n_fail++;
      $display("FAIL mid_reset wr_j: got %b %h %h, required 1 03 02", bus.s_wren, bus.s_address, bus.s_data);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.s_address, bus.s_wren, bus.s_data, bus.e_address, bus.d_address,
         bus.d_wren, bus.d_data, done, fail} !== 44'd0) begin
      n_fail++;
      $display("FAIL mid_reset outputs: got %h, required 0",
               {bus.s_address, bus.s_wren, bus.s_data, bus.e_address, bus.d_address,
                bus.d_wren, bus.d_data, done, fail});
    end
    reset = 1'b0;
    load(8'h63, 8'h60, 8'h66, 1'b0);
    run_scored("restart", 0, 1'b0);
    n_checks++;
    if ({d_mem[0], d_mem[1], d_mem[2]} !== 24'h616561) begin
      n_fail++;
      $display("FAIL restart d: got %h %h %h, required 61 65 61", d_mem[0], d_mem[1], d_mem[2]);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_identity_zero();
    test_identity_text();
    test_j_wrap();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
